// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared state encoding, requester count and ALU width defaults for alu_arbiter.
package alu_arb_pkg;
    localparam int NREQ = 2;
    localparam int DEF_DATA_W = 6;
    localparam int DEF_FXN_W = 3;
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t EXEC = 2'd1;
    localparam state_t RESP = 2'd2;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between two requesters and alu_arbiter.
interface alu_arb_if import alu_arb_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FXN_W = DEF_FXN_W
);
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [NREQ*FXN_W-1:0] req_fxn;
    logic [NREQ*DATA_W-1:0] req_a;
    logic [NREQ*DATA_W-1:0] req_b;
    logic [NREQ-1:0] rsp_valid;
    logic [NREQ-1:0] rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic rsp_oflow;
    logic rsp_cout;
    modport master (
        output req_valid, req_fxn, req_a, req_b, rsp_ready,
        input req_ready, rsp_valid, rsp_result, rsp_oflow, rsp_cout
    );
    modport slave (
        input req_valid, req_fxn, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_oflow, rsp_cout
    );
endinterface

// File: rtl/arb_2way.sv
// arb_2way: one-hot grant for two requesters; round-robin pointer when ALU_ARB_RR_EN is defined,
// otherwise fixed priority to req[0].
module arb_2way (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       advance,
    output logic [1:0] grant
);
`ifdef ALU_ARB_RR_EN
    logic rr;
    // ptr is the requester just served, so the other one gets priority next
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rr <= 1'b0;
        else if (advance) rr <= ~ptr;
    assign grant = (&req) ? (rr ? 2'b10 : 2'b01) : req;
`else
    logic unused;
    assign unused = ^{clk, rst_n, ptr, advance};
    assign grant = req[0] ? 2'b01 : req;
`endif
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one mini ALU between two valid/ready requesters (IDLE->EXEC->RESP).
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority to req0.
module alu_arbiter import alu_arb_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FXN_W = DEF_FXN_W,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arb_if.slave          bus,
    output logic [FXN_W-1:0]  alu_fxn,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_oflow,
    input  logic              alu_cout
);
    localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    state_t state;
    logic owner, win, accept, done;
    logic [CW-1:0] cnt;
    logic [NREQ-1:0] req_idle, grant;
    logic [FXN_W-1:0] op_fxn;
    logic [DATA_W-1:0] op_a, op_b, result;
    logic oflow, cout;
    assign req_idle = (state == IDLE) ? bus.req_valid : '0;
    arb_2way u_arb (
        .clk(clk),
        .rst_n(rst_n),
        .req(req_idle),
        .ptr(owner),
        .advance(done),
        .grant(grant)
    );
    // ready is gated by reset so every output reads 0 while rst_n is low
    assign bus.req_ready = (state == IDLE && rst_n) ? grant : '0;
    assign bus.rsp_valid = (state == RESP) ? (NREQ'(1) << owner) : '0;
    assign bus.rsp_result = result;
    assign bus.rsp_oflow = oflow;
    assign bus.rsp_cout = cout;
    assign alu_fxn = op_fxn;
    assign alu_a = op_a;
    assign alu_b = op_b;
    assign win = grant[1];
    assign accept = |(bus.req_valid & bus.req_ready);
    assign done = (state == RESP) && bus.rsp_ready[owner];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
            cnt <= '0;
            op_fxn <= '0;
            op_a <= '0;
            op_b <= '0;
            result <= '0;
            oflow <= 1'b0;
            cout <= 1'b0;
        end else if (state == IDLE && accept) begin
            state <= EXEC;
            owner <= win;
            cnt <= '0;
            op_fxn <= bus.req_fxn[win*FXN_W +: FXN_W];
            op_a <= bus.req_a[win*DATA_W +: DATA_W];
            op_b <= bus.req_b[win*DATA_W +: DATA_W];
        end else if (state == EXEC) begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(EXEC_CYCLES - 1)) begin
                result <= alu_out;
                oflow <= alu_oflow;
                cout <= alu_cout;
                state <= RESP;
            end
        end else if (done) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural 6-bit add/sub ALU.
// Build with or without ALU_ARB_RR_EN; the arbitration checks follow the macro.
module tb_alu_arbiter;
    import alu_arb_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] alu_fxn;
    logic [5:0] alu_a, alu_b, alu_out, bop;
    logic [6:0] sum;
    logic alu_oflow, alu_cout;
    logic saw_r1 = 1'b0;
    logic mon = 1'b0;
    int checks = 0;
    int errors = 0;
    alu_arb_if bus ();
    alu_arbiter #(.EXEC_CYCLES(1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .alu_fxn(alu_fxn),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_out(alu_out),
        .alu_oflow(alu_oflow),
        .alu_cout(alu_cout)
    );
    // fxn LSB 0 = add, 1 = subtract (a + ~b + 1)
    assign bop = alu_fxn[0] ? ~alu_b : alu_b;
    assign sum = {1'b0, alu_a} + {1'b0, bop} + 7'(alu_fxn[0]);
    assign alu_out = sum[5:0];
    assign alu_cout = sum[6];
    assign alu_oflow = (alu_a[5] == bop[5]) && (sum[5] != alu_a[5]);
    always #5 clk = ~clk;
    always @(negedge clk) if (mon && bus.req_ready[1]) saw_r1 = 1'b1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic issue(input int id, input logic [2:0] f, input logic [5:0] a, input logic [5:0] b);
        int n = 0;
        @(negedge clk);
        bus.req_valid[id] = 1'b1;
        bus.req_fxn[id*3 +: 3] = f;
        bus.req_a[id*6 +: 6] = a;
        bus.req_b[id*6 +: 6] = b;
        #1;
        while (!bus.req_ready[id] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.req_ready[id]) check("ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[id] = 1'b0;
    endtask
    task automatic wait_rsp();
        for (int i = 0; i < 20 && bus.rsp_valid == 0; i++) @(negedge clk);
        if (bus.rsp_valid == 0) check("rsp_timeout", 0, 1);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.req_valid = '0;
        bus.req_fxn = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 2'b11;
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_result", bus.rsp_result, 0);
        rst_n = 1'b1;
        // 1: req0 add 40+30 -> 6 with carry
        @(negedge clk);
        bus.req_valid = 2'b01;
        bus.req_a = {6'd0, 6'd40};
        bus.req_b = {6'd0, 6'd30};
        #1 check("t1_ready", bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        check("t1_exec_no_rsp", bus.rsp_valid, 0);
        @(negedge clk);
        check("t1_rsp_valid", bus.rsp_valid, 1);
        check("t1_result", bus.rsp_result, 6);
        check("t1_cout", bus.rsp_cout, 1);
        check("t1_oflow", bus.rsp_oflow, 0);
        @(negedge clk);
        check("t1_rsp_drop", bus.rsp_valid, 0);
        // 2: req1 subtract 5-10 -> 59
        issue(1, 3'd1, 6'd5, 6'd10);
        wait_rsp();
        check("t2_rsp_valid", bus.rsp_valid, 2);
        check("t2_result", bus.rsp_result, 59);
        @(negedge clk);
        // 3/4: both requesters valid continuously
        bus.req_fxn = '0;
        bus.req_a = {6'd10, 6'd1};
        bus.req_b = {6'd20, 6'd2};
        bus.req_valid = 2'b11;
        mon = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int id;
`ifdef ALU_ARB_RR_EN
            id = k % 2;
`else
            id = 0;
`endif
            wait_rsp();
            check("t3_owner", bus.rsp_valid, 1 << id);
            check("t3_result", bus.rsp_result, id ? 30 : 3);
            if (k < 3) @(negedge clk);
        end
        bus.req_valid = 2'b00;
        mon = 1'b0;
`ifdef ALU_ARB_RR_EN
        check("t3_r1_granted", saw_r1, 1);
`else
        check("t4_r1_starved", saw_r1, 0);
`endif
        @(negedge clk);
        // 5: response back-pressure for 5 cycles with req1 waiting
        bus.rsp_ready = 2'b00;
        issue(0, 3'd0, 6'd7, 6'd8);
        bus.req_valid[1] = 1'b1;
        bus.req_a[11:6] = 6'd3;
        bus.req_b[11:6] = 6'd4;
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", bus.rsp_valid, 1);
            check("t5_hold_result", bus.rsp_result, 15);
            check("t5_no_ready", bus.req_ready, 0);
            @(negedge clk);
        end
        check("t5_still_valid", bus.rsp_valid, 1);
        bus.rsp_ready = 2'b11;
        @(negedge clk);
        check("t5_done", bus.rsp_valid, 0);
        check("t5_next_ready", bus.req_ready, 2);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b00;
        wait_rsp();
        check("t5_r1_valid", bus.rsp_valid, 2);
        check("t5_r1_result", bus.rsp_result, 7);
        @(negedge clk);
        // 6: reset while in EXEC discards the operation
        issue(0, 3'd0, 6'd20, 6'd20);
        rst_n = 1'b0;
        #1;
        check("t6_rsp_valid", bus.rsp_valid, 0);
        check("t6_alu_a", alu_a, 0);
        check("t6_alu_b", alu_b, 0);
        check("t6_req_ready", bus.req_ready, 0);
        check("t6_result", bus.rsp_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t6_no_rsp", bus.rsp_valid, 0);
        end
        issue(0, 3'd0, 6'd1, 6'd1);
        wait_rsp();
        check("t6_after_valid", bus.rsp_valid, 1);
        check("t6_after_result", bus.rsp_result, 2);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
